// File: rtl/exec_operand_stage_if.sv
// exec_operand_stage_if: upstream beat, bypass operands and downstream result bus of the execute operand stage
interface exec_operand_stage_if #(
   parameter int DATA_W  = 16,
   parameter int NUM_BYP = 2,
   parameter int CNT_W   = 16
);
   logic                      enable_execute;
   logic                      in_ready;
   logic [5:0]                E_control;
   logic [15:0]               IR;
   logic [DATA_W-1:0]         npc_in;
   logic                      Mem_Control_in;
   logic [1:0]                W_Control_in;
   logic [DATA_W-1:0]         VSR1;
   logic [DATA_W-1:0]         VSR2;
   logic [NUM_BYP-1:0]        byp_sel1;
   logic [NUM_BYP-1:0]        byp_sel2;
   logic [NUM_BYP*DATA_W-1:0] byp_val;
   logic                      out_valid;
   logic                      out_ready;
   logic [5:0]                E_control_out;
   logic [15:0]               IR_out;
   logic [DATA_W-1:0]         npc_out;
   logic                      Mem_Control_out;
   logic [1:0]                W_Control_out;
   logic [DATA_W-1:0]         opA;
   logic [DATA_W-1:0]         opB;
   logic [CNT_W-1:0]          issue_cnt;
   modport master (
      output enable_execute, E_control, IR, npc_in, Mem_Control_in, W_Control_in,
             VSR1, VSR2, byp_sel1, byp_sel2, byp_val, out_ready,
      input  in_ready, out_valid, E_control_out, IR_out, npc_out, Mem_Control_out,
             W_Control_out, opA, opB, issue_cnt
   );
   modport slave (
      input  enable_execute, E_control, IR, npc_in, Mem_Control_in, W_Control_in,
             VSR1, VSR2, byp_sel1, byp_sel2, byp_val, out_ready,
      output in_ready, out_valid, E_control_out, IR_out, npc_out, Mem_Control_out,
             W_Control_out, opA, opB, issue_cnt
   );
endinterface

// File: rtl/exec_operand_stage.sv
// exec_operand_stage: resolves bypassed operands at acceptance and registers the beat; EXEC_OPERAND_SKID_EN adds a skid entry
module exec_operand_stage #(
   parameter int DATA_W  = 16,
   parameter int NUM_BYP = 2,
   parameter int CNT_W   = 16
) (
   input logic                 clock,
   input logic                 reset,
   exec_operand_stage_if.slave bus
);
   localparam int BW = 25 + 3 * DATA_W;
   logic [DATA_W-1:0] res_a, res_b;
   logic [BW-1:0]     in_beat, out_beat;
   logic              out_valid, accept, deliver;
   logic [CNT_W-1:0]  issue_cnt;
   // lowest-index set select wins, so scan channels from the top down
   always_comb begin
      res_a = bus.VSR1;
      res_b = bus.VSR2;
      for (int k = NUM_BYP - 1; k >= 0; k--) begin
         if (bus.byp_sel1[k]) res_a = bus.byp_val[k*DATA_W +: DATA_W];
         if (bus.byp_sel2[k]) res_b = bus.byp_val[k*DATA_W +: DATA_W];
      end
   end
   assign in_beat = {bus.E_control, bus.IR, bus.npc_in, bus.Mem_Control_in, bus.W_Control_in, res_a, res_b};
   assign accept  = bus.enable_execute && bus.in_ready;
   assign deliver = out_valid && bus.out_ready;
   assign {bus.E_control_out, bus.IR_out, bus.npc_out, bus.Mem_Control_out, bus.W_Control_out, bus.opA, bus.opB} = out_beat;
   assign bus.out_valid = out_valid;
   assign bus.issue_cnt = issue_cnt;
`ifdef EXEC_OPERAND_SKID_EN
   logic          skid_valid;
   logic [BW-1:0] skid_beat;
   assign bus.in_ready = !skid_valid;
   // output register refills from skid first to keep order; a beat arriving against a stalled output parks in skid
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         out_valid  <= 1'b0;
         out_beat   <= '0;
         skid_valid <= 1'b0;
         skid_beat  <= '0;
      end else if (deliver && skid_valid) begin
         out_beat   <= skid_beat;
         skid_valid <= 1'b0;
      end else if (accept && (!out_valid || deliver)) begin
         out_valid <= 1'b1;
         out_beat  <= in_beat;
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_beat  <= in_beat;
      end else if (deliver)
         out_valid <= 1'b0;
`else
   assign bus.in_ready = !out_valid || bus.out_ready;
   // single output register, replaced in the same cycle it is delivered
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         out_valid <= 1'b0;
         out_beat  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_beat  <= in_beat;
      end else if (deliver)
         out_valid <= 1'b0;
`endif
   // count of beats handed downstream, wrapping naturally
   always_ff @(posedge clock or negedge reset)
      if (!reset) issue_cnt <= '0;
      else if (deliver) issue_cnt <= issue_cnt + 1'b1;
endmodule
